// File: rtl/qav_pkg.sv
// Shared constants and the header classification rule for the Qav tx frame classifier.
package qav_pkg;

  localparam logic [15:0] QAV_TPID_VLAN = 16'h8100;
  localparam int          QAV_HDR_BYTES = 15;
  localparam int          QAV_PCP_LSB   = 5;

  localparam logic [1:0] ST_COLLECT = 2'd0;
  localparam logic [1:0] ST_REPLAY  = 2'd1;
  localparam logic [1:0] ST_PASS    = 2'd2;

  localparam logic SEL_LEGACY = 1'b0;
  localparam logic SEL_AV     = 1'b1;

  // A frame is AV only when it is VLAN tagged and its PCP is enabled in the mask.
  function automatic logic qav_is_av_frame(input logic [15:0] tpid,
                                           input logic [7:0]  tci_hi,
                                           input logic [7:0]  pcp_mask,
                                           input logic        av_en);
    logic [2:0] pcp;
    pcp = tci_hi[QAV_PCP_LSB +: 3];
    return av_en && (tpid == QAV_TPID_VLAN) && pcp_mask[pcp];
  endfunction

endpackage

// File: rtl/qav_frame_classifier_if.sv
// Byte-wide AXI-Stream bundle used for the client input and both tx FIFO channels.
interface qav_axis_if;

  logic [7:0] tdata;
  logic       tvalid;
  logic       tready;
  logic       tlast;

  modport master (
    output tdata,
    output tvalid,
    output tlast,
    input  tready
  );

  modport slave (
    input  tdata,
    input  tvalid,
    input  tlast,
    output tready
  );

endinterface

// File: rtl/qav_hdr_buffer.sv
// Small register file holding the first header bytes of a frame, with a tap on the TPID bytes.
module qav_hdr_buffer
  import qav_pkg::*;
#(
  parameter int DEPTH = QAV_HDR_BYTES
) (
  input  logic        clk_i,
  input  logic        clr_i,
  input  logic        wr_en_i,
  input  logic [3:0]  wr_addr_i,
  input  logic [7:0]  wr_data_i,
  input  logic [3:0]  rd_addr_i,
  output logic [7:0]  rd_data_o,
  output logic [15:0] tpid_o
);

  logic [7:0] mem_q [DEPTH];

  always_ff @(posedge clk_i) begin
    if (clr_i) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else if (wr_en_i) begin
      mem_q[wr_addr_i] <= wr_data_i;
    end
  end

  assign rd_data_o = mem_q[rd_addr_i];

  // Bytes 12/13 hold the TPID once the header is collected.
  assign tpid_o = {mem_q[12], mem_q[13]};

endmodule

// File: rtl/qav_frame_classifier.sv
// Splits one client byte stream into legacy and AV tx channels, whole frames only.
// Define QAV_CLASSIFIER_STATS_EN to add per-channel completed-frame counters.
module qav_frame_classifier
  import qav_pkg::*;
#(
  parameter int         HDR_BYTES   = QAV_HDR_BYTES,
  parameter logic [7:0] AV_PCP_MASK = 8'h0C
`ifdef QAV_CLASSIFIER_STATS_EN
  ,
  parameter int         CNT_W       = 32
`endif
) (
  input  logic       tx_fifo_clock,
  input  logic       tx_fifo_reset,
  input  logic       av_enable,
  qav_axis_if.slave  s_axis,
  qav_axis_if.master tx_axis_fifo_legacy,
  qav_axis_if.master tx_axis_fifo_av
`ifdef QAV_CLASSIFIER_STATS_EN
  ,
  output logic [CNT_W-1:0] frame_cnt_legacy,
  output logic [CNT_W-1:0] frame_cnt_av
`endif
);

  localparam logic [3:0] LAST_HDR = 4'(HDR_BYTES - 1);

  logic [1:0]  state_q, state_d;
  logic [3:0]  wr_ptr_q, wr_ptr_d;
  logic [3:0]  rd_ptr_q, rd_ptr_d;
  logic [3:0]  len_q, len_d;
  logic        sel_q, sel_d;
  logic        short_q, short_d;

  logic        s_ready;
  logic        out_valid;
  logic        out_last;
  logic [7:0]  out_data;
  logic        out_ready;
  logic        in_hs;
  logic        out_hs;
  logic        decide;
  logic        last_replay;
  logic        buf_wr_en;
  logic [7:0]  buf_rd_data;
  logic [15:0] buf_tpid;

  assign buf_wr_en = (state_q == ST_COLLECT) && in_hs;

  qav_hdr_buffer #(
    .DEPTH (HDR_BYTES)
  ) u_hdr_buffer (
    .clk_i     (tx_fifo_clock),
    .clr_i     (tx_fifo_reset),
    .wr_en_i   (buf_wr_en),
    .wr_addr_i (wr_ptr_q),
    .wr_data_i (s_axis.tdata),
    .rd_addr_i (rd_ptr_q),
    .rd_data_o (buf_rd_data),
    .tpid_o    (buf_tpid)
  );

  assign out_ready   = (sel_q == SEL_AV) ? tx_axis_fifo_av.tready : tx_axis_fifo_legacy.tready;
  assign in_hs       = s_axis.tvalid && s_ready;
  assign out_hs      = out_valid && out_ready;
  assign decide      = (state_q == ST_COLLECT) && in_hs && ((wr_ptr_q == LAST_HDR) || s_axis.tlast);
  assign last_replay = (rd_ptr_q == (len_q - 4'd1));

  // Selected-channel datapath; reset forces everything quiet in the reset cycle itself.
  always_comb begin
    s_ready   = 1'b0;
    out_valid = 1'b0;
    out_last  = 1'b0;
    out_data  = 8'h00;
    case (state_q)
      ST_COLLECT: s_ready = 1'b1;
      ST_REPLAY: begin
        out_valid = 1'b1;
        out_data  = buf_rd_data;
        out_last  = short_q && last_replay;
      end
      ST_PASS: begin
        out_valid = s_axis.tvalid;
        out_data  = s_axis.tdata;
        out_last  = s_axis.tlast;
        s_ready   = out_ready;
      end
      default: ;
    endcase
    if (tx_fifo_reset) begin
      s_ready   = 1'b0;
      out_valid = 1'b0;
      out_last  = 1'b0;
      out_data  = 8'h00;
    end
  end

  always_comb begin
    state_d  = state_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    len_d    = len_q;
    sel_d    = sel_q;
    short_d  = short_q;
    case (state_q)
      ST_COLLECT: begin
        if (decide) begin
          // A frame ending inside the header window never qualifies for AV.
          short_d = s_axis.tlast;
          sel_d   = (!s_axis.tlast && qav_is_av_frame(buf_tpid, s_axis.tdata, AV_PCP_MASK, av_enable))
                    ? SEL_AV : SEL_LEGACY;
          len_d   = wr_ptr_q + 4'd1;
          state_d = ST_REPLAY;
        end else if (in_hs) begin
          wr_ptr_d = wr_ptr_q + 4'd1;
        end
      end
      ST_REPLAY: begin
        if (out_hs) begin
          rd_ptr_d = rd_ptr_q + 4'd1;
          if (last_replay) begin
            rd_ptr_d = 4'd0;
            wr_ptr_d = 4'd0;
            state_d  = short_q ? ST_COLLECT : ST_PASS;
          end
        end
      end
      ST_PASS: begin
        if (in_hs && s_axis.tlast) begin
          state_d = ST_COLLECT;
        end
      end
      default: state_d = ST_COLLECT;
    endcase
  end

  always_ff @(posedge tx_fifo_clock) begin
    if (tx_fifo_reset) begin
      state_q  <= ST_COLLECT;
      wr_ptr_q <= 4'd0;
      rd_ptr_q <= 4'd0;
      len_q    <= 4'd0;
      sel_q    <= SEL_LEGACY;
      short_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      len_q    <= len_d;
      sel_q    <= sel_d;
      short_q  <= short_d;
    end
  end

  assign s_axis.tready = s_ready;

  assign tx_axis_fifo_legacy.tvalid = out_valid && (sel_q == SEL_LEGACY);
  assign tx_axis_fifo_legacy.tdata  = (sel_q == SEL_LEGACY) ? out_data : 8'h00;
  assign tx_axis_fifo_legacy.tlast  = out_last && (sel_q == SEL_LEGACY);

  assign tx_axis_fifo_av.tvalid = out_valid && (sel_q == SEL_AV);
  assign tx_axis_fifo_av.tdata  = (sel_q == SEL_AV) ? out_data : 8'h00;
  assign tx_axis_fifo_av.tlast  = out_last && (sel_q == SEL_AV);

`ifdef QAV_CLASSIFIER_STATS_EN
  logic [CNT_W-1:0] cnt_legacy_q;
  logic [CNT_W-1:0] cnt_av_q;

  always_ff @(posedge tx_fifo_clock) begin
    if (tx_fifo_reset) begin
      cnt_legacy_q <= '0;
      cnt_av_q     <= '0;
    end else if (out_hs && out_last) begin
      if (sel_q == SEL_AV) begin
        cnt_av_q <= cnt_av_q + CNT_W'(1);
      end else begin
        cnt_legacy_q <= cnt_legacy_q + CNT_W'(1);
      end
    end
  end

  assign frame_cnt_legacy = cnt_legacy_q;
  assign frame_cnt_av     = cnt_av_q;
`endif

endmodule

// File: tb/tb_qav_frame_classifier.sv
// Self-checking bench for qav_frame_classifier: random frames against a frame-level routing model.
module tb_qav_frame_classifier;

  localparam logic [7:0] AvPcpMask = 8'h0C;

  logic clk = 1'b0;
  logic reset;
  logic avEnable;

  qav_axis_if sAxis();
  qav_axis_if legAxis();
  qav_axis_if avAxis();

`ifdef QAV_CLASSIFIER_STATS_EN
  logic [31:0] cntLegacy;
  logic [31:0] cntAv;
`endif

  qav_frame_classifier #(
    .AV_PCP_MASK (AvPcpMask)
  ) dut (
    .tx_fifo_clock       (clk),
    .tx_fifo_reset       (reset),
    .av_enable           (avEnable),
    .s_axis              (sAxis),
    .tx_axis_fifo_legacy (legAxis),
    .tx_axis_fifo_av     (avAxis)
`ifdef QAV_CLASSIFIER_STATS_EN
    ,
    .frame_cnt_legacy    (cntLegacy),
    .frame_cnt_av        (cntAv)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int readyMode = 0;
  int expCntLeg = 0;
  int expCntAv = 0;

  logic [7:0] frame[$];
  logic [8:0] legQ[$];
  logic [8:0] avQ[$];

  int   legBase, avBase, outBase, legValidBase, avValidBase, replayBase, bothBase;
  int   legValidCnt = 0;
  int   avValidCnt = 0;
  int   replayErr = 0;
  int   bothValidErr = 0;
  int   validRiseCyc = -1;
  logic prevAnyValid = 1'b0;
  int   hdrCyc = -1;
  int   curLen = 0;
  logic hdrSeen = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  // Sink readiness: 0 = always ready, 1 = toggle every cycle, 2 = random.
  initial begin
    legAxis.tready = 1'b1;
    avAxis.tready  = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      case (readyMode)
        1: begin
          legAxis.tready = ~legAxis.tready;
          avAxis.tready  = ~avAxis.tready;
        end
        2: begin
          legAxis.tready = 1'($urandom_range(0, 1));
          avAxis.tready  = 1'($urandom_range(0, 1));
        end
        default: begin
          legAxis.tready = 1'b1;
          avAxis.tready  = 1'b1;
        end
      endcase
    end
  end

  always @(negedge clk) begin
    if (hdrSeen && (legQ.size() + avQ.size() - outBase) < ((curLen < 15) ? curLen : 15) && sAxis.tready)
      replayErr++;
    if (legAxis.tvalid && avAxis.tvalid) bothValidErr++;
    if (legAxis.tvalid) legValidCnt++;
    if (avAxis.tvalid) avValidCnt++;
    if (!prevAnyValid && (legAxis.tvalid || avAxis.tvalid)) validRiseCyc = cyc;
    prevAnyValid = legAxis.tvalid || avAxis.tvalid;
    if (legAxis.tvalid && legAxis.tready) legQ.push_back({legAxis.tlast, legAxis.tdata});
    if (avAxis.tvalid && avAxis.tready) avQ.push_back({avAxis.tlast, avAxis.tdata});
  end

  // Routing rule at frame level: short frames (15 bytes or fewer) are legacy.
  function automatic bit exp_is_av(input logic [7:0] f[$], input bit en);
    logic [7:0] mask;
    logic [2:0] pcp;
    mask = AvPcpMask;
    if (f.size() <= 15) return 1'b0;
    pcp = f[14][7:5];
    return en && (f[12] == 8'h81) && (f[13] == 8'h00) && mask[pcp];
  endfunction

  // Index of the first byte that differs in data or tlast placement, -1 if identical.
  function automatic int first_diff(input logic [8:0] q[$], input int base, input logic [7:0] f[$]);
    int n;
    n = q.size() - base;
    for (int i = 0; i < f.size(); i++) begin
      if (i >= n) return i;
      if (q[base + i][7:0] !== f[i] || q[base + i][8] !== (i == f.size() - 1)) return i;
    end
    if (n != f.size()) return f.size();
    return -1;
  endfunction

  task automatic make_frame(input int len, input logic [15:0] tpid, input logic [7:0] tci);
    frame.delete();
    for (int i = 0; i < len; i++) frame.push_back(8'($urandom));
    if (len > 13) begin
      frame[12] = tpid[15:8];
      frame[13] = tpid[7:0];
    end
    if (len > 14) frame[14] = tci;
  endtask

  task automatic begin_frame();
    hdrSeen      = 1'b0;
    legBase      = legQ.size();
    avBase       = avQ.size();
    outBase      = legBase + avBase;
    legValidBase = legValidCnt;
    avValidBase  = avValidCnt;
    replayBase   = replayErr;
    bothBase     = bothValidErr;
    curLen       = frame.size();
  endtask

  task automatic send_frame(input int stopAt);
    int  hdrIdx;
    bit  got;
    int  guard;
    hdrIdx = ((frame.size() < 15) ? frame.size() : 15) - 1;
    hdrCyc = -1;
    for (int i = 0; i < frame.size(); i++) begin
      got   = 1'b0;
      guard = 0;
      sAxis.tdata  = frame[i];
      sAxis.tvalid = 1'b1;
      sAxis.tlast  = (i == frame.size() - 1);
      while (!got && guard < 2000) begin
        @(negedge clk);
        if (sAxis.tready) begin
          got = 1'b1;
          if (i == hdrIdx) hdrCyc = cyc;
        end
        @(posedge clk);
        #1;
        guard++;
        if (got && i == hdrIdx) hdrSeen = 1'b1;
      end
      if (!got) begin
        checks++;
        failures++;
        $display("[TB] FAIL input_accept: byte %0d tready=0 for 2000 cycles, required 1", i);
        break;
      end
      if (i == stopAt) break;
    end
    sAxis.tvalid = 1'b0;
    sAxis.tlast  = 1'b0;
    sAxis.tdata  = 8'h00;
  endtask

  task automatic wait_frame(output bit done);
    done = 1'b0;
    for (int k = 0; k < 3000 && !done; k++) begin
      @(negedge clk);
      if (legQ.size() > legBase && legQ[legQ.size() - 1][8]) done = 1'b1;
      if (avQ.size() > avBase && avQ[avQ.size() - 1][8]) done = 1'b1;
    end
    repeat (3) @(negedge clk);
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if (sAxis.tready !== 1'b0) begin failures++; $display("[TB] FAIL reset_s_tready: got %b required 0", sAxis.tready); end
    checks++;
    if ({legAxis.tvalid, avAxis.tvalid, legAxis.tlast, avAxis.tlast} !== 4'b0000) begin
      failures++; $display("[TB] FAIL reset_out_ctrl: got %b required 0000", {legAxis.tvalid, avAxis.tvalid, legAxis.tlast, avAxis.tlast});
    end
    checks++;
    if ({legAxis.tdata, avAxis.tdata} !== 16'h0000) begin
      failures++; $display("[TB] FAIL reset_out_data: got %h required 0000", {legAxis.tdata, avAxis.tdata});
    end
    @(posedge clk);
    #1;
    reset = 1'b0;
    expCntLeg = 0;
    expCntAv = 0;
    @(negedge clk);
    checks++;
    if (sAxis.tready !== 1'b1) begin failures++; $display("[TB] FAIL collect_s_tready: got %b required 1", sAxis.tready); end
    checks++;
    if ({legAxis.tvalid, avAxis.tvalid} !== 2'b00) begin
      failures++; $display("[TB] FAIL idle_tvalid: got %b required 00", {legAxis.tvalid, avAxis.tvalid});
    end
`ifdef QAV_CLASSIFIER_STATS_EN
    checks++;
    if (cntLegacy !== 32'd0 || cntAv !== 32'd0) begin
      failures++; $display("[TB] FAIL reset_counters: got %0d/%0d required 0/0", cntLegacy, cntAv);
    end
`endif
    @(posedge clk);
    #1;
  endtask

  task automatic test_av_frame();
    bit done;
    int d;
    readyMode = 0;
    avEnable = 1'b1;
    make_frame(64, 16'h8100, 8'h60);
    begin_frame();
    send_frame(-1);
    wait_frame(done);
    checks++;
    if (done !== 1'b1) begin failures++; $display("[TB] FAIL av64_done: got %b required 1", done); end
    checks++;
    if (exp_is_av(frame, 1'b1) !== 1'b1) begin failures++; $display("[TB] FAIL av64_model: got 0 required 1"); end
    d = first_diff(avQ, avBase, frame);
    checks++;
    if (d !== -1) begin failures++; $display("[TB] FAIL av64_data: first bad index %0d required -1", d); end
    checks++;
    if (legValidCnt - legValidBase !== 0) begin
      failures++; $display("[TB] FAIL av64_legacy_quiet: got %0d valid cycles required 0", legValidCnt - legValidBase);
    end
    expCntAv++;
`ifdef QAV_CLASSIFIER_STATS_EN
    checks++;
    if (cntAv !== 32'(expCntAv) || cntLegacy !== 32'(expCntLeg)) begin
      failures++; $display("[TB] FAIL av64_counters: got %0d/%0d required %0d/%0d", cntLegacy, cntAv, expCntLeg, expCntAv);
    end
`endif
  endtask

  task automatic test_av_disabled();
    bit done;
    int d;
    readyMode = 0;
    avEnable = 1'b0;
    make_frame(64, 16'h8100, 8'h60);
    begin_frame();
    send_frame(-1);
    wait_frame(done);
    d = first_diff(legQ, legBase, frame);
    checks++;
    if (d !== -1 || done !== 1'b1) begin failures++; $display("[TB] FAIL avdis_data: first bad index %0d done %b required -1/1", d, done); end
    checks++;
    if (avValidCnt - avValidBase !== 0) begin
      failures++; $display("[TB] FAIL avdis_av_quiet: got %0d valid cycles required 0", avValidCnt - avValidBase);
    end
    expCntLeg++;
`ifdef QAV_CLASSIFIER_STATS_EN
    checks++;
    if (cntLegacy !== 32'(expCntLeg) || cntAv !== 32'(expCntAv)) begin
      failures++; $display("[TB] FAIL avdis_counters: got %0d/%0d required %0d/%0d", cntLegacy, cntAv, expCntLeg, expCntAv);
    end
`endif
    avEnable = 1'b1;
  endtask

  task automatic test_untagged_latency();
    bit done;
    int d;
    readyMode = 0;
    avEnable = 1'b1;
    make_frame(40, 16'h0800, 8'h60);
    begin_frame();
    send_frame(-1);
    wait_frame(done);
    d = first_diff(legQ, legBase, frame);
    checks++;
    if (d !== -1 || done !== 1'b1) begin failures++; $display("[TB] FAIL untagged_data: first bad index %0d done %b required -1/1", d, done); end
    checks++;
    if (validRiseCyc - hdrCyc !== 1) begin
      failures++; $display("[TB] FAIL untagged_latency: got %0d cycles required 1", validRiseCyc - hdrCyc);
    end
    expCntLeg++;
  endtask

  task automatic test_short_frames();
    bit done;
    int d;
    int lens[3] = '{10, 15, 16};
    readyMode = 0;
    avEnable = 1'b1;
    foreach (lens[n]) begin
      make_frame(lens[n], 16'h8100, 8'h60);
      begin_frame();
      send_frame(-1);
      wait_frame(done);
      d = exp_is_av(frame, 1'b1) ? first_diff(avQ, avBase, frame) : first_diff(legQ, legBase, frame);
      checks++;
      if (d !== -1 || done !== 1'b1) begin
        failures++; $display("[TB] FAIL short_len%0d_data: first bad index %0d done %b required -1/1", lens[n], d, done);
      end
      checks++;
      if ((legQ.size() - legBase) + (avQ.size() - avBase) !== lens[n]) begin
        failures++; $display("[TB] FAIL short_len%0d_count: got %0d bytes required %0d", lens[n], (legQ.size() - legBase) + (avQ.size() - avBase), lens[n]);
      end
      if (exp_is_av(frame, 1'b1)) expCntAv++; else expCntLeg++;
    end
    checks++;
    if (avQ.size() - avBase !== 16) begin
      failures++; $display("[TB] FAIL after_runt_av: got %0d av bytes required 16", avQ.size() - avBase);
    end
  endtask

  task automatic test_backpressure();
    bit done;
    int d;
    readyMode = 1;
    avEnable = 1'b1;
    make_frame(64, 16'h8100, 8'h6A);
    begin_frame();
    send_frame(-1);
    wait_frame(done);
    readyMode = 0;
    d = first_diff(avQ, avBase, frame);
    checks++;
    if (d !== -1 || done !== 1'b1) begin failures++; $display("[TB] FAIL bp_data: first bad index %0d done %b required -1/1", d, done); end
    checks++;
    if (replayErr - replayBase !== 0) begin
      failures++; $display("[TB] FAIL bp_replay_stall: got %0d cycles with s_tready=1 required 0", replayErr - replayBase);
    end
    checks++;
    if (legValidCnt - legValidBase !== 0 || bothValidErr - bothBase !== 0) begin
      failures++; $display("[TB] FAIL bp_unselected_quiet: got %0d/%0d required 0/0", legValidCnt - legValidBase, bothValidErr - bothBase);
    end
    expCntAv++;
  endtask

  task automatic test_reset_mid_frame();
    bit done;
    int d;
    readyMode = 0;
    avEnable = 1'b1;
    make_frame(64, 16'h8100, 8'h60);
    begin_frame();
    send_frame(30);
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    hdrSeen = 1'b0;
    expCntLeg = 0;
    expCntAv = 0;
    @(negedge clk);
    checks++;
    if ({legAxis.tvalid, avAxis.tvalid} !== 2'b00) begin
      failures++; $display("[TB] FAIL midreset_tvalid: got %b required 00", {legAxis.tvalid, avAxis.tvalid});
    end
`ifdef QAV_CLASSIFIER_STATS_EN
    checks++;
    if (cntLegacy !== 32'd0 || cntAv !== 32'd0) begin
      failures++; $display("[TB] FAIL midreset_counters: got %0d/%0d required 0/0", cntLegacy, cntAv);
    end
`endif
    @(posedge clk);
    #1;
    make_frame(48, 16'h8100, 8'h45);
    begin_frame();
    send_frame(-1);
    wait_frame(done);
    d = first_diff(avQ, avBase, frame);
    checks++;
    if (d !== -1 || done !== 1'b1) begin failures++; $display("[TB] FAIL midreset_pcp2_data: first bad index %0d done %b required -1/1", d, done); end
    expCntAv++;
  endtask

  task automatic test_random();
    bit done;
    int d;
    bit expAv;
    logic [15:0] tpid;
    for (int n = 0; n < 10; n++) begin
      readyMode = 2;
      avEnable = 1'($urandom_range(0, 3) != 0);
      case ($urandom_range(0, 2))
        0: tpid = 16'h0800;
        1: tpid = 16'($urandom);
        default: tpid = 16'h8100;
      endcase
      make_frame($urandom_range(5, 48), tpid, 8'($urandom));
      expAv = exp_is_av(frame, avEnable);
      begin_frame();
      send_frame(-1);
      wait_frame(done);
      d = expAv ? first_diff(avQ, avBase, frame) : first_diff(legQ, legBase, frame);
      checks++;
      if (d !== -1 || done !== 1'b1) begin
        failures++; $display("[TB] FAIL rand%0d_data: len %0d av %b first bad index %0d done %b required -1/1", n, frame.size(), expAv, d, done);
      end
      checks++;
      if ((expAv ? (legValidCnt - legValidBase) : (avValidCnt - avValidBase)) !== 0 || replayErr - replayBase !== 0) begin
        failures++; $display("[TB] FAIL rand%0d_side: got unselected %0d replay %0d required 0/0", n,
                             expAv ? (legValidCnt - legValidBase) : (avValidCnt - avValidBase), replayErr - replayBase);
      end
      if (expAv) expCntAv++; else expCntLeg++;
    end
    readyMode = 0;
`ifdef QAV_CLASSIFIER_STATS_EN
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (cntLegacy !== 32'(expCntLeg) || cntAv !== 32'(expCntAv)) begin
      failures++; $display("[TB] FAIL rand_counters: got %0d/%0d required %0d/%0d", cntLegacy, cntAv, expCntLeg, expCntAv);
    end
`endif
  endtask

  initial begin
    reset        = 1'b1;
    avEnable     = 1'b1;
    sAxis.tdata  = 8'h00;
    sAxis.tvalid = 1'b0;
    sAxis.tlast  = 1'b0;
    test_reset();
    test_av_frame();
    test_av_disabled();
    test_untagged_latency();
    test_short_frames();
    test_backpressure();
    test_reset_mid_frame();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
